tb_status_periph: RTL and testbench

TB_STATUS_PERIPH -- requirements
Module: tb_status_periph

---
 rtl/tb_status_periph.sv | 190 +++++++++++++++++++
 tb/tb_tb_status_periph.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tb_status_periph.sv
// Status peripheral for simulation benches: character stdout FIFO,
// program exit register and sticky pass/fail verdict on a simple
// req/gnt/rvalid data bus.
// Optional free-running timer with compare interrupt is compiled in when
// the macro TB_STATUS_PERIPH_TIMER_EN is defined; without it the timer
// addresses read as zero and ignore writes.
module tb_status_periph #(
  parameter int          STDOUT_DEPTH = 8,
  parameter logic [31:0] PASS_MAGIC   = 32'd123456789
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        stdout_valid_o,
  input  logic        stdout_ready_i,
  output logic [7:0]  stdout_data_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
`ifdef TB_STATUS_PERIPH_TIMER_EN
  ,
  output logic        timer_irq_o
`endif
);

  localparam int AW = $clog2(STDOUT_DEPTH);

  localparam logic [2:0] SEL_STDOUT    = 3'd0;
  localparam logic [2:0] SEL_EXIT      = 3'd1;
  localparam logic [2:0] SEL_TEST      = 3'd2;
  localparam logic [2:0] SEL_TIMER_CMP = 3'd3;
  localparam logic [2:0] SEL_TIMER_CNT = 3'd4;

  logic [2:0]    sel;
  logic          fifo_full;
  logic          wr_en;
  logic          push;
  logic          pop;
  logic          verdict_done;
  logic [31:0]   rd_mux;
  logic          unused_addr;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [STDOUT_DEPTH];

  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          passed_q, passed_d;
  logic          failed_q, failed_d;
  logic          exit_valid_q, exit_valid_d;
  logic [31:0]   exit_value_q, exit_value_d;

`ifdef TB_STATUS_PERIPH_TIMER_EN
  logic [31:0]   timer_cnt_q, timer_cnt_d;
  logic [31:0]   timer_cmp_q, timer_cmp_d;
`endif

  // Address decode and bus handshake; stdout writes stall only while full.
  always_comb begin
    sel         = addr_i[4:2];
    unused_addr = ^{addr_i[31:5], addr_i[1:0]};
    fifo_full   = (count_q == (AW+1)'(STDOUT_DEPTH));
    gnt_o       = req_i & ~(we_i & (sel == SEL_STDOUT) & fifo_full);
    wr_en       = gnt_o & we_i & (|be_i);
    push        = wr_en & (sel == SEL_STDOUT);
    pop         = stdout_valid_o & stdout_ready_i;
  end

  // Stdout FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Stream side of the FIFO; data held at zero while empty.
  always_comb begin
    stdout_valid_o = (count_q != '0);
    stdout_data_o  = stdout_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  end

  // FIFO storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i[7:0];
  end

  // Verdict registers: the first of pass, fail or exit freezes all three.
  always_comb begin
    verdict_done = passed_q | failed_q | exit_valid_q;
    passed_d     = passed_q;
    failed_d     = failed_q;
    exit_valid_d = exit_valid_q;
    exit_value_d = exit_value_q;
    if (wr_en && !verdict_done) begin
      if (sel == SEL_EXIT) begin
        exit_valid_d = 1'b1;
        exit_value_d = wdata_i;
      end else if (sel == SEL_TEST) begin
        if (wdata_i == PASS_MAGIC)  passed_d = 1'b1;
        else if (wdata_i == 32'd1)  failed_d = 1'b1;
      end
    end
  end

`ifdef TB_STATUS_PERIPH_TIMER_EN
  // Free-running counter; a bus write overrides the increment.
  always_comb begin
    timer_cnt_d = timer_cnt_q + 32'd1;
    timer_cmp_d = timer_cmp_q;
    if (wr_en && sel == SEL_TIMER_CNT) timer_cnt_d = wdata_i;
    if (wr_en && sel == SEL_TIMER_CMP) timer_cmp_d = wdata_i;
    timer_irq_o = (timer_cnt_q == timer_cmp_q) && (timer_cmp_q != 32'd0);
  end
`endif

  // Read mux and response generation; write responses carry zero data.
  always_comb begin
    rd_mux = 32'h0;
    case (sel)
      SEL_STDOUT:    rd_mux = {{(31-AW){1'b0}}, count_q};
      SEL_EXIT:      rd_mux = exit_value_q;
      SEL_TEST:      rd_mux = {30'b0, failed_q, passed_q};
`ifdef TB_STATUS_PERIPH_TIMER_EN
      SEL_TIMER_CMP: rd_mux = timer_cmp_q;
      SEL_TIMER_CNT: rd_mux = timer_cnt_q;
`endif
      default:       rd_mux = 32'h0;
    endcase
    rvalid_d = gnt_o;
    rdata_d  = (gnt_o && !we_i) ? rd_mux : 32'h0;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'h0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= 32'h0;
`ifdef TB_STATUS_PERIPH_TIMER_EN
      timer_cnt_q  <= 32'h0;
      timer_cmp_q  <= 32'h0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
`ifdef TB_STATUS_PERIPH_TIMER_EN
      timer_cnt_q  <= timer_cnt_d;
      timer_cmp_q  <= timer_cmp_d;
`endif
    end
  end

  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_tb_status_periph.sv
// Bench for tb_status_periph: directed scenarios followed by a random
// phase, all checked cycle by cycle against a queue-based reference model.
module tb_tb_status_periph;

  localparam int          DEPTH = 8;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, sr;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, sv, passed, failed, exv;
  logic [31:0] rdata, exval;
  logic [7:0]  sd;
`ifdef TB_STATUS_PERIPH_TIMER_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  q[$];
  logic        m_pass, m_fail, m_exv;
  logic [31:0] m_exval;
`ifdef TB_STATUS_PERIPH_TIMER_EN
  logic [31:0] m_cnt, m_cmp;
  int          irq_pulses;
`endif

  tb_status_periph #(.STDOUT_DEPTH(DEPTH), .PASS_MAGIC(MAGIC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .stdout_valid_o(sv), .stdout_ready_i(sr), .stdout_data_o(sd),
    .tests_passed_o(passed), .tests_failed_o(failed),
    .exit_valid_o(exv), .exit_value_o(exval)
`ifdef TB_STATUS_PERIPH_TIMER_EN
    , .timer_irq_o(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_pass = 0; m_fail = 0; m_exv = 0; m_exval = 0;
`ifdef TB_STATUS_PERIPH_TIMER_EN
    m_cnt = 0; m_cmp = 0;
`endif
  endtask

  // One bus cycle: drive, check pre-edge outputs, clock, update model, check response.
  task automatic cycle(input logic r, input logic w, input logic [2:0] idx,
                       input logic [31:0] wd, input logic [3:0] b, input logic rdy);
    logic        eg, ep, done;
    logic [31:0] er;
    req = r; we = w; addr = {27'h0, idx, 2'b00}; wdata = wd; be = b; sr = rdy;
    #1;
    eg = r && !(w && idx == 3'd0 && q.size() == DEPTH);
    check("gnt", 32'(gnt), 32'(eg));
    check("stdout_valid", 32'(sv), 32'(q.size() != 0));
    check("stdout_data", 32'(sd), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check("passed", 32'(passed), 32'(m_pass));
    check("failed", 32'(failed), 32'(m_fail));
    check("exit_valid", 32'(exv), 32'(m_exv));
    check("exit_value", exval, m_exval);
`ifdef TB_STATUS_PERIPH_TIMER_EN
    check("timer_irq", 32'(irq), 32'(m_cnt == m_cmp && m_cmp != 0));
    if (irq === 1'b1) irq_pulses++;
`endif
    er = 32'h0;
    case (idx)
      3'd0: er = 32'(q.size());
      3'd1: er = m_exval;
      3'd2: er = {30'b0, m_fail, m_pass};
`ifdef TB_STATUS_PERIPH_TIMER_EN
      3'd3: er = m_cmp;
      3'd4: er = m_cnt;
`endif
      default: er = 32'h0;
    endcase
    @(posedge clk);
    done = m_pass | m_fail | m_exv;
    ep = (q.size() != 0) && rdy;
    if (ep) void'(q.pop_front());
`ifdef TB_STATUS_PERIPH_TIMER_EN
    m_cnt = m_cnt + 1;
`endif
    if (eg && w && b != 4'h0) begin
      if (idx == 3'd0) q.push_back(wd[7:0]);
      if (!done && idx == 3'd1) begin m_exv = 1; m_exval = wd; end
      if (!done && idx == 3'd2) begin
        if (wd == MAGIC) m_pass = 1;
        else if (wd == 32'd1) m_fail = 1;
      end
`ifdef TB_STATUS_PERIPH_TIMER_EN
      if (idx == 3'd3) m_cmp = wd;
      if (idx == 3'd4) m_cnt = wd;
`endif
    end
    #1;
    check("rvalid", 32'(rvalid), 32'(eg));
    if (eg && !w) check("rdata", rdata, er);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 3'd7, 32'h0, 4'h0, rdy);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input logic r);
    rst_n = 1'b0; req = r; we = 1'b1; addr = 32'h0; wdata = 32'h0; be = 4'hf; sr = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'(r));
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_stdout_valid", 32'(sv), 32'h0);
    check("rst_stdout_data", 32'(sd), 32'h0);
    check("rst_verdict", {29'h0, passed, failed, exv}, 32'h0);
    check("rst_exit_value", exval, 32'h0);
    model_clear();
    @(posedge clk);
    #2;
    req = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_rvalid", 32'(rvalid), 32'h0);
  endtask

  initial begin
    logic [2:0]  ridx;
    logic [31:0] rwd;
    req = 0; we = 0; addr = 0; wdata = 0; be = 0; sr = 0;
    rst_n = 1'b1;
    model_clear();
`ifdef TB_STATUS_PERIPH_TIMER_EN
    irq_pulses = 0;
`endif
    #3;
    do_reset(1'b0);
    do_reset(1'b1);

    // "Hi" with a ready printer
    cycle(1, 1, 3'd0, 32'h48, 4'hf, 1);
    cycle(1, 1, 3'd0, 32'h69, 4'hf, 1);
    idle(1);
    idle(1);
    cycle(1, 0, 3'd0, 32'h0, 4'hf, 1);

    // Fill to full with printer stalled, ninth write held off
    for (int k = 0; k < 9; k++) cycle(1, 1, 3'd0, 32'h61 + k, 4'hf, 0);
    cycle(1, 1, 3'd0, 32'h69, 4'hf, 1);
    cycle(1, 1, 3'd0, 32'h69, 4'hf, 0);
    cycle(1, 0, 3'd0, 32'h0, 4'hf, 0);
    // Count 7, then simultaneous push and pop
    idle(1);
    cycle(1, 1, 3'd0, 32'h7a, 4'hf, 1);
    cycle(1, 0, 3'd0, 32'h0, 4'hf, 0);
    // Zero byte-enable write is granted but ignored
    cycle(1, 1, 3'd0, 32'h55, 4'h0, 0);
    cycle(1, 0, 3'd0, 32'h0, 4'hf, 0);
    for (int k = 0; k < 4; k++) idle(1);
    // Reset with entries still queued
    do_reset(1'b0);
    idle(0);

    // Pass verdict, later fail ignored
    cycle(1, 1, 3'd2, MAGIC, 4'hf, 0);
    cycle(1, 1, 3'd2, 32'd1, 4'hf, 0);
    cycle(1, 0, 3'd2, 32'h0, 4'hf, 0);
    cycle(1, 1, 3'd1, 32'h33, 4'hf, 0);
    cycle(1, 0, 3'd1, 32'h0, 4'hf, 0);

    // Exit value sticks at the first write
    do_reset(1'b0);
    cycle(1, 1, 3'd1, 32'h2a, 4'hf, 0);
    cycle(1, 1, 3'd1, 32'h0, 4'hf, 0);
    cycle(1, 0, 3'd1, 32'h0, 4'hf, 0);
    cycle(1, 1, 3'd2, MAGIC, 4'hf, 0);
    cycle(1, 0, 3'd2, 32'h0, 4'hf, 0);

    // Reset right after a grant discards the response
    cycle(1, 0, 3'd1, 32'h0, 4'hf, 0);
    do_reset(1'b0);
    idle(0);

    // Unmapped and timer space
    cycle(1, 1, 3'd6, 32'hdead, 4'hf, 0);
    cycle(1, 0, 3'd6, 32'h0, 4'hf, 0);
    cycle(1, 0, 3'd5, 32'h0, 4'hf, 0);
`ifdef TB_STATUS_PERIPH_TIMER_EN
    cycle(1, 1, 3'd3, 32'd10, 4'hf, 0);
    cycle(1, 1, 3'd4, 32'd0, 4'hf, 0);
    irq_pulses = 0;
    for (int k = 0; k < 14; k++) idle(0);
    check("irq_pulse_count", 32'(irq_pulses), 32'd1);
    cycle(1, 0, 3'd4, 32'h0, 4'hf, 0);
    cycle(1, 0, 3'd3, 32'h0, 4'hf, 0);
    cycle(1, 1, 3'd3, 32'd0, 4'hf, 0);
`else
    cycle(1, 1, 3'd4, 32'h5, 4'hf, 0);
    cycle(1, 0, 3'd4, 32'h0, 4'hf, 0);
    cycle(1, 0, 3'd3, 32'h0, 4'hf, 0);
`endif

    // Random traffic
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1'b0);
      ridx = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 19))
        0:       rwd = MAGIC;
        1:       rwd = 32'd1;
        default: rwd = $urandom;
      endcase
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), ridx, rwd,
            ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
            1'($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
